// File: rtl/ext_pipe_pkg.sv
// Shared definitions for the immediate/load-data extender: mode encodings and default widths.
package ext_pkg;
  localparam logic [2:0] EXT_SIGN   = 3'd0;
  localparam logic [2:0] EXT_ZERO   = 3'd1;
  localparam logic [2:0] EXT_UPPER  = 3'd2;
  localparam logic [2:0] EXT_BRANCH = 3'd3;
  localparam logic [2:0] EXT_BYTE_S = 3'd4;
  localparam logic [2:0] EXT_BYTE_Z = 3'd5;
  localparam logic [2:0] EXT_HALF_S = 3'd6;
  localparam logic [2:0] EXT_RSVD   = 3'd7;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_SHAMT = 2;
  localparam int DEF_TAG_W = 5;
endpackage

// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: upstream beat channel, downstream result channel and err.
interface ext_pipe_if
  import ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int TAG_W = DEF_TAG_W
) ();
  // A beat moves on a channel at a rising edge where valid and ready are both high;
  // valid never waits on ready, and a held result stays stable until taken.
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [2:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             err;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, err
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, err
  );
endinterface

// File: rtl/ext_pipe_core.sv
// Combinational extender: maps an IN_W-bit field to OUT_W bits according to the mode.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHAMT = DEF_SHAMT
) (
  input  logic [IN_W-1:0]  d,
  input  logic [2:0]       mode,
  output logic [OUT_W-1:0] result,
  output logic             rsvd
);
  localparam int EXT = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  assign sext = {{EXT{d[IN_W-1]}}, d};

  always_comb begin
    result = '0;
    rsvd   = 1'b0;
    case (mode)
      EXT_SIGN:   result = sext;
      EXT_ZERO:   result = {{EXT{1'b0}}, d};
      EXT_UPPER:  result = {d, {EXT{1'b0}}};
      EXT_BRANCH: result = sext << SHAMT;
      EXT_BYTE_S: result = {{(OUT_W-8){d[7]}}, d[7:0]};
      EXT_BYTE_Z: result = {{(OUT_W-8){1'b0}}, d[7:0]};
      EXT_HALF_S: result = {{(OUT_W-16){d[15]}}, d[15:0]};
      default:    rsvd   = 1'b1;
    endcase
  end
endmodule

// File: rtl/ext_pipe.sv
// Registered extender stage: main register M drives the outputs, skid register S absorbs
// the one beat that arrives while M is stalled, so in_ready depends only on flops.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHAMT = DEF_SHAMT,
  parameter int TAG_W = DEF_TAG_W
) (
  input logic        clk,
  input logic        rst_n,
  input logic        flush,
  ext_pipe_if.slave  bus
);
  logic [OUT_W-1:0] ext_result;
  logic             ext_rsvd;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) u_core (
    .d      (bus.in_data),
    .mode   (bus.in_mode),
    .result (ext_result),
    .rsvd   (ext_rsvd)
  );

  logic             m_valid, s_valid, err_q;
  logic [OUT_W-1:0] m_data, s_data;
  logic [TAG_W-1:0] m_tag, s_tag;
  logic             accept, m_free;

  assign accept = bus.in_valid & ~s_valid;
  // M can take a new value when it is empty or its current beat leaves this edge.
  assign m_free = ~m_valid | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tag   <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_tag   <= '0;
      err_q   <= 1'b0;
    end else begin
      // A reserved mode marks err even when flush discards the beat itself.
      if (accept && ext_rsvd) err_q <= 1'b1;
      if (flush) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else if (m_free) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          m_tag   <= s_tag;
          s_valid <= 1'b0;
        end else if (accept) begin
          m_valid <= 1'b1;
          m_data  <= ext_result;
          m_tag   <= bus.in_tag;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (accept) begin
        s_valid <= 1'b1;
        s_data  <= ext_result;
        s_tag   <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready  = ~s_valid;
  assign bus.out_valid = m_valid;
  assign bus.out_data  = m_data;
  assign bus.out_tag   = m_tag;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: vector table for the modes, scoreboarded stream under
// backpressure, and hand-written stall, flush, reserved-mode and async-reset sequences.
module tb_ext_pipe;
  import ext_pkg::*;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  logic clk;
  logic rst_n;
  logic flush;

  ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(2), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [TAG_W+OUT_W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]       mode;
    logic [IN_W-1:0]  data;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 3'd0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [2:0] mode, input logic [IN_W-1:0] data,
                      input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = data;
    bus.in_tag   = tag;
  endtask

  // independent reference written arithmetically
  function automatic logic [OUT_W-1:0] ref_ext(input logic [2:0] m, input logic [15:0] d);
    logic signed [31:0] sd, sb;
    sd = $signed(d);
    sb = $signed(d[7:0]);
    case (m)
      3'd0: ref_ext = sd;
      3'd1: ref_ext = {16'h0000, d};
      3'd2: ref_ext = {16'h0000, d} * 32'd65536;
      3'd3: ref_ext = sd * 4;
      3'd4: ref_ext = sb;
      3'd5: ref_ext = {24'h0, d[7:0]};
      3'd6: ref_ext = sd;
      default: ref_ext = 32'h0;
    endcase
  endfunction

  task automatic run_stream(input int n);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic [15:0] d;
    logic [TAG_W+OUT_W-1:0] e;
    while (got < n && cyc < 200) begin
      d = 16'h8000 ^ 16'(sent * 16'h1357);
      bus.in_valid  = (sent < n);
      bus.in_tag    = TAG_W'(sent + 1);
      bus.in_mode   = 3'(sent % 7);
      bus.in_data   = d;
      bus.out_ready = (cyc % 3 == 0);
      @(negedge clk);
      chk("stream_out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      chk("stream_in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_beat", 64'(bus.out_tag), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_tag", 64'(bus.out_tag), 64'(e[TAG_W+OUT_W-1:OUT_W]));
          chk("stream_data", 64'(bus.out_data), 64'(e[OUT_W-1:0]));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.in_tag, ref_ext(bus.in_mode, bus.in_data)});
        sent++;
      end
      step();
      cyc++;
    end
    if (got < n) chk("stream_timeout", 64'(got), 64'(n));
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = '{EXT_SIGN,   16'h8001, 32'hFFFF8001};
    vecs[1]  = '{EXT_ZERO,   16'h8001, 32'h00008001};
    vecs[2]  = '{EXT_UPPER,  16'h8001, 32'h80010000};
    vecs[3]  = '{EXT_BRANCH, 16'h8001, 32'hFFFE0004};
    vecs[4]  = '{EXT_BYTE_S, 16'h0080, 32'hFFFFFF80};
    vecs[5]  = '{EXT_BYTE_Z, 16'h0080, 32'h00000080};
    vecs[6]  = '{EXT_HALF_S, 16'h8001, 32'hFFFF8001};
    vecs[7]  = '{EXT_SIGN,   16'h7FFF, 32'h00007FFF};
    vecs[8]  = '{EXT_UPPER,  16'h0001, 32'h00010000};
    vecs[9]  = '{EXT_BRANCH, 16'h0001, 32'h00000004};
    vecs[10] = '{EXT_BRANCH, 16'hFFFF, 32'hFFFFFFFC};
    vecs[11] = '{EXT_BYTE_S, 16'h127F, 32'h0000007F};
    vecs[12] = '{EXT_BYTE_Z, 16'h12FF, 32'h000000FF};
    vecs[13] = '{EXT_HALF_S, 16'h7FFF, 32'h00007FFF};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_data", 64'(bus.out_data), 64'h0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'h0);
    chk("rst_err", 64'(bus.err), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    rst_n = 1'b1;
    step();

    // mode table, one beat per cycle with the consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].mode, vecs[i].data, TAG_W'(i + 1));
      step();
      chk("vec_out_valid", 64'(bus.out_valid), 64'h1);
      chk($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(vecs[i].exp));
      chk("vec_out_tag", 64'(bus.out_tag), 64'(i + 1));
      chk("vec_in_ready", 64'(bus.in_ready), 64'h1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("vec_drain_valid", 64'(bus.out_valid), 64'h0);
    chk("vec_err_clear", 64'(bus.err), 64'h0);

    run_stream(6);
    run_stream(12);

    // stall then burst
    idle_inputs();
    send(EXT_ZERO, 16'h00A1, 5'd10);
    step();
    send(EXT_ZERO, 16'h00B2, 5'd11);
    step();
    chk("stall_in_ready_low", 64'(bus.in_ready), 64'h0);
    chk("stall_head_tag", 64'(bus.out_tag), 64'd10);
    send(EXT_ZERO, 16'h00C3, 5'd12);
    step();
    chk("stall_third_blocked", 64'(bus.in_ready), 64'h0);
    chk("stall_out_stable", 64'(bus.out_data), 64'h000000A1);
    bus.out_ready = 1'b1;
    step();
    chk("burst_second_tag", 64'(bus.out_tag), 64'd11);
    chk("burst_second_data", 64'(bus.out_data), 64'h000000B2);
    chk("burst_in_ready_back", 64'(bus.in_ready), 64'h1);
    step();
    chk("burst_third_tag", 64'(bus.out_tag), 64'd12);
    chk("burst_third_data", 64'(bus.out_data), 64'h000000C3);
    bus.in_valid = 1'b0;
    step();
    chk("burst_empty", 64'(bus.out_valid), 64'h0);

    // flush with both registers occupied and a beat offered
    idle_inputs();
    send(EXT_SIGN, 16'h1111, 5'd20);
    step();
    send(EXT_SIGN, 16'h2222, 5'd21);
    step();
    chk("flush_pre_full", 64'(bus.in_ready), 64'h0);
    send(EXT_SIGN, 16'h3333, 5'd22);
    flush = 1'b1;
    step();
    idle_inputs();
    chk("flush_out_valid", 64'(bus.out_valid), 64'h0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'h1);
    bus.out_ready = 1'b1;
    step();
    chk("flush_no_ghost", 64'(bus.out_valid), 64'h0);

    // reserved beat discarded by flush still marks err
    send(EXT_RSVD, 16'hFFFF, 5'd23);
    flush = 1'b1;
    step();
    idle_inputs();
    chk("flush_rsvd_valid", 64'(bus.out_valid), 64'h0);
    chk("flush_rsvd_err", 64'(bus.err), 64'h1);

    do_reset();
    chk("reset_clears_err", 64'(bus.err), 64'h0);

    // reserved mode
    bus.out_ready = 1'b1;
    send(EXT_RSVD, 16'hFFFF, 5'd24);
    step();
    chk("rsvd_valid", 64'(bus.out_valid), 64'h1);
    chk("rsvd_data", 64'(bus.out_data), 64'h0);
    chk("rsvd_err", 64'(bus.err), 64'h1);
    send(EXT_ZERO, 16'h0042, 5'd25);
    step();
    chk("rsvd_next_data", 64'(bus.out_data), 64'h00000042);
    chk("rsvd_err_sticky", 64'(bus.err), 64'h1);
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("rsvd_err_held", 64'(bus.err), 64'h1);

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    send(EXT_SIGN, 16'h8001, 5'd26);
    step();
    send(EXT_SIGN, 16'h8002, 5'd27);
    step();
    chk("arst_pre_valid", 64'(bus.out_valid), 64'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("arst_out_data", 64'(bus.out_data), 64'h0);
    chk("arst_out_tag", 64'(bus.out_tag), 64'h0);
    chk("arst_err", 64'(bus.err), 64'h0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'h1);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("arst_no_stale_beat", 64'(bus.out_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
